// File: rtl/sdrc_app_arbiter.sv
// Two-port round-robin arbiter in front of the SDRAM controller application interface.
// One transaction is in flight at a time; re-arbitration happens only after the burst's last transfer.
module sdrc_app_arbiter #(
  parameter int APP_AW = 30,
  parameter int APP_DW = 32,
  parameter int APP_BW = 4,
  parameter int APP_RW = 9
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              m0_req,
  input  logic [APP_AW-1:0] m0_req_addr,
  input  logic [APP_RW-1:0] m0_req_len,
  input  logic              m0_req_wr_n,
  output logic              m0_req_ack,
  input  logic [APP_DW-1:0] m0_wr_data,
  input  logic [APP_BW-1:0] m0_wr_en_n,
  output logic              m0_wr_next,
  output logic              m0_last_wr,
  output logic [APP_DW-1:0] m0_rd_data,
  output logic              m0_rd_valid,
  output logic              m0_last_rd,

  input  logic              m1_req,
  input  logic [APP_AW-1:0] m1_req_addr,
  input  logic [APP_RW-1:0] m1_req_len,
  input  logic              m1_req_wr_n,
  output logic              m1_req_ack,
  input  logic [APP_DW-1:0] m1_wr_data,
  input  logic [APP_BW-1:0] m1_wr_en_n,
  output logic              m1_wr_next,
  output logic              m1_last_wr,
  output logic [APP_DW-1:0] m1_rd_data,
  output logic              m1_rd_valid,
  output logic              m1_last_rd,

  output logic              app_req,
  output logic [APP_AW-1:0] app_req_addr,
  output logic [APP_RW-1:0] app_req_len,
  output logic              app_req_wr_n,
  input  logic              app_req_ack,
  output logic [APP_DW-1:0] app_wr_data,
  output logic [APP_BW-1:0] app_wr_en_n,
  input  logic              app_wr_next,
  input  logic              app_last_wr,
  input  logic [APP_DW-1:0] app_rd_data,
  input  logic              app_rd_valid,
  input  logic              app_last_rd,

  output logic              arb_owner,
  output logic              arb_busy
);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

  state_t state, state_nxt, route_state;
  logic   owner, owner_nxt;
  logic   last_served, last_served_nxt;

  // Owner-selected request fields.
  logic              sel_req;
  logic [APP_AW-1:0] sel_addr;
  logic [APP_RW-1:0] sel_len;
  logic              sel_wr_n;
  logic [APP_DW-1:0] sel_wr_data;
  logic [APP_BW-1:0] sel_wr_en_n;

  assign sel_req     = owner ? m1_req      : m0_req;
  assign sel_addr    = owner ? m1_req_addr : m0_req_addr;
  assign sel_len     = owner ? m1_req_len  : m0_req_len;
  assign sel_wr_n    = owner ? m1_req_wr_n : m0_req_wr_n;
  assign sel_wr_data = owner ? m1_wr_data  : m0_wr_data;
  assign sel_wr_en_n = owner ? m1_wr_en_n  : m0_wr_en_n;

  // Routing is cut off while reset is asserted, so an in-flight burst stops immediately.
  assign route_state = reset_n ? state : IDLE;

  assign arb_busy  = (state != IDLE);
  assign arb_owner = owner;

  // NOTE: reset here is synchronous, so reset_n is sampled on clk and is absent from the sensitivity list.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_served <= last_served_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    last_served_nxt = last_served;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the requester not served last wins; a lone requester always wins.
          owner_nxt = (m0_req && m1_req) ? ~last_served : m1_req;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (app_req_ack) begin
          last_served_nxt = owner;
          state_nxt       = sel_wr_n ? RDATA : WDATA;
        end
      end
      WDATA: if (app_last_wr) state_nxt = IDLE;
      RDATA: if (app_last_rd) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    app_req      = 1'b0;
    app_req_addr = '0;
    app_req_len  = '0;
    app_req_wr_n = 1'b0;
    app_wr_data  = '0;
    app_wr_en_n  = '1;
    m0_req_ack   = 1'b0;
    m1_req_ack   = 1'b0;
    m0_wr_next   = 1'b0;
    m1_wr_next   = 1'b0;
    m0_last_wr   = 1'b0;
    m1_last_wr   = 1'b0;
    m0_rd_data   = '0;
    m1_rd_data   = '0;
    m0_rd_valid  = 1'b0;
    m1_rd_valid  = 1'b0;
    m0_last_rd   = 1'b0;
    m1_last_rd   = 1'b0;
    case (route_state)
      REQ: begin
        app_req      = sel_req;
        app_req_addr = sel_addr;
        app_req_len  = sel_len;
        app_req_wr_n = sel_wr_n;
        m0_req_ack   = ~owner & app_req_ack;
        m1_req_ack   =  owner & app_req_ack;
      end
      WDATA: begin
        app_wr_data = sel_wr_data;
        app_wr_en_n = sel_wr_en_n;
        m0_wr_next  = ~owner & app_wr_next;
        m1_wr_next  =  owner & app_wr_next;
        m0_last_wr  = ~owner & app_last_wr;
        m1_last_wr  =  owner & app_last_wr;
      end
      RDATA: begin
        m0_rd_data  = app_rd_data;
        m1_rd_data  = app_rd_data;
        m0_rd_valid = ~owner & app_rd_valid;
        m1_rd_valid =  owner & app_rd_valid;
        m0_last_rd  = ~owner & app_last_rd;
        m1_last_rd  =  owner & app_last_rd;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/sdrc_app_arbiter.md
# sdrc_app_arbiter

Two-port round-robin arbiter that shares the SDRAM controller application interface (request, write-data and read-data channels, upstream of the bus-width converter) between two requesters. It grants one requester at a time, forwards its request until accepted, then routes that burst's write/read data until the burst's last transfer, and only then re-arbitrates. Only one transaction is outstanding through the arbiter at any time.

## Interface
- APP_AW, 30, application address width
- APP_DW, 32, application data width
- APP_BW, 4, application byte-enable width
- APP_RW, 9, application request length width
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- m0_req / m1_req  in  1  requester request; held high until its ack
- m0_req_addr / m1_req_addr  in  APP_AW  request address
- m0_req_len / m1_req_len  in  APP_RW  burst length
- m0_req_wr_n / m1_req_wr_n  in  1  0 = write, 1 = read
- m0_req_ack / m1_req_ack  out  1  request accepted (one-cycle pulse)
- m0_wr_data / m1_wr_data  in  APP_DW  write data
- m0_wr_en_n / m1_wr_en_n  in  APP_BW  active-low byte enables
- m0_wr_next / m1_wr_next  out  1  write data consumed
- m0_last_wr / m1_last_wr  out  1  last write transfer of burst
- m0_rd_data / m1_rd_data  out  APP_DW  read data (broadcast)
- m0_rd_valid / m1_rd_valid  out  1  read data valid
- m0_last_rd / m1_last_rd  out  1  last read transfer of burst
- app_req, app_req_addr, app_req_len, app_req_wr_n  out  1/APP_AW/APP_RW/1  to controller
- app_req_ack  in  1  controller accepted request
- app_wr_data, app_wr_en_n  out  APP_DW/APP_BW  to controller
- app_wr_next, app_last_wr  in  1  from controller
- app_rd_data  in  APP_DW; app_rd_valid, app_last_rd  in  1  from controller
- arb_owner  out  1  registered grant index; arb_busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, WDATA, RDATA (registered). Registers: state, owner, last_served.
- IDLE: if any mN_req, pick winner, owner <= winner, go REQ. Both requesting: winner = requester other than last_served. Single requester wins regardless of last_served.
- REQ: app_req/addr/len/wr_n driven from owner's inputs (combinational mux). Non-owner ack = 0. owner ack = app_req_ack. On app_req_ack: last_served <= owner; go WDATA if owner's req_wr_n = 0, else RDATA.
- WDATA: app_wr_data/app_wr_en_n = owner's; owner's wr_next/last_wr = app_wr_next/app_last_wr; non-owner's = 0. On app_last_wr = 1 go IDLE.
- RDATA: all mN_rd_data = app_rd_data; owner's rd_valid/last_rd = app_rd_valid/app_last_rd; non-owner's = 0. On app_last_rd = 1 go IDLE.
- Outside REQ: app_req = 0, app_req_addr/len/wr_n = 0. Outside WDATA: app_wr_data = 0, app_wr_en_n = all ones. All mN_wr_next/last_wr/rd_valid/last_rd = 0 outside their data state.
- app_last_wr in RDATA/REQ/IDLE and app_last_rd in WDATA/REQ/IDLE are ignored (no state change).
- Requester dropping req while in REQ before ack: protocol violation; arbiter stays in REQ (not required to recover).

## Timing
- Reset: state IDLE, owner 0, last_served 1 (m0 wins first tie); arb_busy 0, arb_owner 0, app_req 0, all acks/next/valid/last 0, app_wr_en_n all ones, data/address outputs 0.
- Grant latency: mN_req high at cycle t in IDLE -> app_req high at t+1.
- Ack passthrough is combinational, same cycle as app_req_ack.
- Data-channel muxes are combinational; zero-cycle latency from controller to owner and owner to controller.
- Burst end: last transfer at cycle t -> IDLE at t+1 -> next app_req no earlier than t+2. Back-to-back bursts therefore have a 2-cycle request gap.
- app_req_ack and last in same REQ cycle: ack taken, last ignored.
- Reset mid-burst: return to IDLE next edge; in-flight data routing stops immediately.

## Test plan
- Single write: m0_req, wr_n=0, addr 0x100, len 4; ack at REQ+2; 4 app_wr_next with last on 4th -> m0_wr_next 4 pulses, m1 sees none, IDLE one cycle after last.
- Tie: m0 and m1 request reads in same cycle after reset -> m0 granted first; after its app_last_rd, m1 granted; arb_owner 0 then 1.
- Fairness: m0 requests continuously, m1 requests once -> grants alternate m0, m1, m0.
- Read routing: m1 read, 8 app_rd_valid with data 0xA5A5_0000+i -> m1_rd_valid 8 pulses with matching data, m0_rd_valid stays 0, m1_last_rd on 8th.
- Stray last: app_last_rd pulsed during WDATA -> state stays WDATA until app_last_wr.
- Reset mid-write: reset_n low in WDATA -> next cycle IDLE, app_wr_en_n = 4'hF, arb_busy 0, last_served 1.
